// File: rtl/pal_cfg_serializer.sv
// Host-side PAL bitstream loader: accepts W-bit words over valid/ready, shifts them
// out LSB-first on CFG_OUT/CFG_SHIFT, then pulses CFG_APPLY after exactly CFG_BITS bits.
module pal_cfg_serializer #(
    parameter  int CFG_BITS     = 280,
    parameter  int W            = 8,
    parameter  int APPLY_CYCLES = 2,
    localparam int CNT_W        = $clog2(CFG_BITS + 1)
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             START,
    input  logic             ABORT,
    input  logic [W-1:0]     WORD_DATA,
    input  logic             WORD_VALID,
    output logic             WORD_READY,
    output logic             CFG_OUT,
    output logic             CFG_SHIFT,
    output logic             CFG_APPLY,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] BIT_COUNT
);

    localparam int LEFT_W = $clog2(W + 1);
    localparam int APP_W  = (APPLY_CYCLES > 1) ? $clog2(APPLY_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_APPLY,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [W-1:0]        r_shreg;
    logic [LEFT_W-1:0]   r_left;
    logic [APP_W-1:0]    r_app_cnt;
    logic [CNT_W-1:0]    r_bit_count;
    logic                r_cfg_out;
    logic                r_cfg_shift;
    logic                r_cfg_apply;

    logic                w_hs;
    logic                w_last_bit;
    logic                w_stream_end;
    logic [CNT_W-1:0]    w_remaining;
    logic [LEFT_W-1:0]   w_word_bits;

    assign w_hs         = WORD_VALID && (r_state == S_LOAD);
    assign w_remaining  = CNT_W'(CFG_BITS) - r_bit_count;
    // The final word may be partial; its surplus high bits are never shifted out.
    assign w_word_bits  = (w_remaining < CNT_W'(W)) ? LEFT_W'(w_remaining) : LEFT_W'(W);
    assign w_last_bit   = (r_left == LEFT_W'(1));
    assign w_stream_end = (r_bit_count == CNT_W'(CFG_BITS - 1));

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (START) w_next = S_LOAD;
            S_LOAD:         if (w_hs) w_next = S_SHIFT;
            S_SHIFT:        if (w_last_bit) w_next = w_stream_end ? S_APPLY : S_LOAD;
            S_APPLY:        if (r_app_cnt == APP_W'(APPLY_CYCLES - 1)) w_next = S_DONE;
            default:        w_next = S_IDLE;
        endcase
        if (ABORT) w_next = S_IDLE;
    end

    // Strobes are registered from the next state so they line up with SHIFT/APPLY cycles.
    always_ff @(posedge CLK) begin
        if (RES || ABORT) begin
            r_shreg     <= '0;
            r_left      <= '0;
            r_app_cnt   <= '0;
            r_bit_count <= '0;
            r_cfg_out   <= 1'b0;
            r_cfg_shift <= 1'b0;
            r_cfg_apply <= 1'b0;
        end else begin
            r_cfg_shift <= (w_next == S_SHIFT);
            r_cfg_apply <= (w_next == S_APPLY);
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (START) r_bit_count <= '0;
                end
                S_LOAD: begin
                    if (w_hs) begin
                        r_cfg_out <= WORD_DATA[0];
                        r_shreg   <= WORD_DATA >> 1;
                        r_left    <= w_word_bits;
                    end
                end
                S_SHIFT: begin
                    r_bit_count <= r_bit_count + 1'b1;
                    r_left      <= r_left - 1'b1;
                    r_app_cnt   <= '0;
                    if (!w_last_bit) begin
                        r_cfg_out <= r_shreg[0];
                        r_shreg   <= r_shreg >> 1;
                    end
                end
                S_APPLY: begin
                    r_app_cnt <= r_app_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign WORD_READY = (r_state == S_LOAD);
    assign BUSY       = (r_state == S_LOAD) || (r_state == S_SHIFT) || (r_state == S_APPLY);
    assign DONE       = (r_state == S_DONE);
    assign CFG_OUT    = r_cfg_out;
    assign CFG_SHIFT  = r_cfg_shift;
    assign CFG_APPLY  = r_cfg_apply;
    assign BIT_COUNT  = r_bit_count;

endmodule

// File: tb/tb_pal_cfg_serializer.sv
// Self-checking bench for pal_cfg_serializer: a full-size (280-bit) and a short (20-bit)
// instance, checked against a bitstream/timing model derived from the word list.
module tb_pal_cfg_serializer;

    localparam int W     = 8;
    localparam int BIG   = 280;
    localparam int SMALL = 20;
    localparam int AC_B  = 2;
    localparam int AC_S  = 3;

    logic       CLK = 1'b0;
    logic       RES = 1'b1;
    logic [7:0] data = '0;
    logic       st[2];
    logic       ab[2];
    logic       vl[2];
    logic       ready[2], cfg[2], shift[2], apply[2], busy[2], done[2];
    logic [8:0] cnt_b;
    logic [4:0] cnt_s;

    logic [7:0] words[64];
    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    pal_cfg_serializer #(.CFG_BITS(BIG), .W(W), .APPLY_CYCLES(AC_B)) u_big (
        .CLK(CLK), .RES(RES), .START(st[0]), .ABORT(ab[0]), .WORD_DATA(data),
        .WORD_VALID(vl[0]), .WORD_READY(ready[0]), .CFG_OUT(cfg[0]), .CFG_SHIFT(shift[0]),
        .CFG_APPLY(apply[0]), .BUSY(busy[0]), .DONE(done[0]), .BIT_COUNT(cnt_b)
    );

    pal_cfg_serializer #(.CFG_BITS(SMALL), .W(W), .APPLY_CYCLES(AC_S)) u_small (
        .CLK(CLK), .RES(RES), .START(st[1]), .ABORT(ab[1]), .WORD_DATA(data),
        .WORD_VALID(vl[1]), .WORD_READY(ready[1]), .CFG_OUT(cfg[1]), .CFG_SHIFT(shift[1]),
        .CFG_APPLY(apply[1]), .BUSY(busy[1]), .DONE(done[1]), .BIT_COUNT(cnt_s)
    );

    typedef struct {
        logic       res, start, abort, valid;
        logic [7:0] d;
        logic       e_busy, e_ready, e_done, e_shift, e_cfg;
        int         e_cnt;
    } vec_t;

    vec_t tv[14];

    function automatic vec_t mk(input logic r, input logic s, input logic a, input logic v,
                                input logic [7:0] d, input logic b, input logic rd,
                                input logic dn, input logic sh, input logic cf, input int c);
        vec_t t;
        t.res = r; t.start = s; t.abort = a; t.valid = v; t.d = d;
        t.e_busy = b; t.e_ready = rd; t.e_done = dn; t.e_shift = sh; t.e_cfg = cf; t.e_cnt = c;
        return t;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int cnt_of(input int sel);
        return (sel != 0) ? int'(cnt_s) : int'(cnt_b);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input int sel, input string tag);
        chk($sformatf("%s_busy%0d", tag, sel),  int'(busy[sel]),  0);
        chk($sformatf("%s_ready%0d", tag, sel), int'(ready[sel]), 0);
        chk($sformatf("%s_done%0d", tag, sel),  int'(done[sel]),  0);
        chk($sformatf("%s_shift%0d", tag, sel), int'(shift[sel]), 0);
        chk($sformatf("%s_apply%0d", tag, sel), int'(apply[sel]), 0);
        chk($sformatf("%s_cfg%0d", tag, sel),   int'(cfg[sel]),   0);
        chk($sformatf("%s_cnt%0d", tag, sel),   cnt_of(sel),      0);
    endtask

    // One load: START, feed words[0..nw-1], collect strobed bits and check them against
    // the word list, plus apply length/placement and overall latency.
    task automatic run_load(input int sel, input int stall_idx, input int stall_len,
                            input int abort_at, input bit rnd, output int first_apply);
        int cb = (sel != 0) ? SMALL : BIG;
        int ac = (sel != 0) ? AC_S : AC_B;
        int nw = (cb + W - 1) / W;
        bit got[$];
        int idx = 0, cyc = 0, apply_n = 0, fa = -1, la = -1, ls = -1, done_cyc = -1;
        int stall_left = stall_len;
        int nbad = 0;
        bit fin = 0, aborting = 0;
        logic [7:0] wv;

        first_apply = -1;
        st[sel] = 1'b1; ab[sel] = 1'b0; vl[sel] = 1'b0;
        tick();
        st[sel] = 1'b0;
        chk("load_start_done", int'(done[sel]), 0);
        chk("load_start_busy", int'(busy[sel]), 1);
        chk("load_start_ready", int'(ready[sel]), 1);
        chk("load_start_cnt", cnt_of(sel), 0);

        while (!fin && cyc < 4000) begin
            cyc++;
            if (aborting) begin
                check_idle(sel, "after_abort");
                chk("abort_no_apply", apply_n, 0);
                ab[sel] = 1'b0; st[sel] = 1'b0; vl[sel] = 1'b0;
                fin = 1;
                break;
            end
            if (shift[sel]) begin
                chk("bitcount_at_strobe", cnt_of(sel), got.size());
                got.push_back(cfg[sel]);
                ls = cyc;
            end
            if (apply[sel]) begin
                if (fa < 0) fa = cyc;
                la = cyc;
                apply_n++;
                chk("apply_only_after_all_bits", got.size(), cb);
            end
            if (ready[sel] && idx >= nw) chk("ready_after_last_word", 1, 0);
            if (done[sel]) begin
                done_cyc = cyc;
                fin = 1;
                break;
            end
            st[sel] = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            data    = 8'($urandom);
            vl[sel] = 1'b0;
            if (abort_at >= 0 && got.size() == abort_at + 1) begin
                ab[sel] = 1'b1; st[sel] = 1'b1; vl[sel] = 1'b1;
                aborting = 1;
            end else if (ready[sel] && idx < nw) begin
                if (idx == stall_idx && stall_left > 0) stall_left--;
                else if (rnd && $urandom_range(0, 2) == 0) vl[sel] = 1'b0;
                else begin
                    vl[sel] = 1'b1;
                    data    = words[idx];
                    idx++;
                end
            end
            tick();
        end
        st[sel] = 1'b0; vl[sel] = 1'b0; ab[sel] = 1'b0;

        if (!fin) begin
            chk("load_timeout", 0, 1);
            return;
        end
        if (abort_at >= 0) return;

        chk("strobe_count", got.size(), cb);
        for (int k = 0; k < cb; k++) begin
            wv = words[k / W];
            if (k >= got.size() || got[k] !== wv[k % W]) nbad++;
        end
        chk("bitstream_bad_bits", nbad, 0);
        chk("apply_cycles", apply_n, ac);
        chk("apply_contiguous", la - fa + 1, ac);
        chk("apply_after_last_strobe", fa, ls + 1);
        chk("done_after_apply", done_cyc, la + 1);
        chk("done_busy", int'(busy[sel]), 0);
        chk("done_cnt", cnt_of(sel), cb);
        chk("done_ready", int'(ready[sel]), 0);
        chk("done_shift", int'(shift[sel]), 0);
        // One LOAD cycle per word, one cycle per bit, plus any stall cycles.
        if (!rnd) chk("apply_latency", fa, nw + cb + stall_len + 1);
        first_apply = fa;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fa0, fa1, fa_tmp;

        tv[0]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        tv[1]  = mk(1, 1, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 0);
        tv[2]  = mk(0, 1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        tv[3]  = mk(0, 1, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
        tv[4]  = mk(0, 1, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
        tv[5]  = mk(0, 0, 0, 1, 8'h5B, 1, 0, 0, 1, 1, 0);
        tv[6]  = mk(0, 0, 0, 1, 8'h00, 1, 0, 0, 1, 1, 1);
        tv[7]  = mk(0, 0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 2);
        tv[8]  = mk(0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        tv[9]  = mk(0, 1, 1, 1, 8'hAA, 0, 0, 0, 0, 0, 0);
        tv[10] = mk(0, 1, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
        tv[11] = mk(0, 0, 1, 1, 8'hFF, 0, 0, 0, 0, 0, 0);
        tv[12] = mk(0, 1, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0);
        tv[13] = mk(1, 0, 0, 1, 8'h01, 0, 0, 0, 0, 0, 0);

        for (int s = 0; s < 2; s++) begin
            st[s] = 1'b0; ab[s] = 1'b0; vl[s] = 1'b0;
        end

        // Reset with random inputs on both instances.
        RES = 1'b1;
        for (int c = 0; c < 2; c++) begin
            for (int s = 0; s < 2; s++) begin
                st[s] = 1'($urandom); ab[s] = 1'($urandom); vl[s] = 1'($urandom);
            end
            data = 8'($urandom);
            tick();
            check_idle(0, "reset");
            check_idle(1, "reset");
        end
        RES = 1'b0;
        for (int s = 0; s < 2; s++) begin
            st[s] = 1'b0; ab[s] = 1'b0; vl[s] = 1'b0;
        end
        tick();

        // Control-path vectors on the short instance.
        for (int i = 0; i < 14; i++) begin
            RES = tv[i].res; st[1] = tv[i].start; ab[1] = tv[i].abort; vl[1] = tv[i].valid;
            data = tv[i].d;
            tick();
            chk($sformatf("vec%0d_busy", i),  int'(busy[1]),  int'(tv[i].e_busy));
            chk($sformatf("vec%0d_ready", i), int'(ready[1]), int'(tv[i].e_ready));
            chk($sformatf("vec%0d_done", i),  int'(done[1]),  int'(tv[i].e_done));
            chk($sformatf("vec%0d_shift", i), int'(shift[1]), int'(tv[i].e_shift));
            chk($sformatf("vec%0d_apply", i), int'(apply[1]), 0);
            if (tv[i].e_shift) chk($sformatf("vec%0d_cfg", i), int'(cfg[1]), int'(tv[i].e_cfg));
            chk($sformatf("vec%0d_cnt", i), cnt_of(1), tv[i].e_cnt);
        end
        RES = 1'b0; st[1] = 1'b0; ab[1] = 1'b0; vl[1] = 1'b0;
        tick();

        // Full 280-bit load, VALID always high; then again from DONE with a 5-cycle stall.
        words[0] = 8'hA5;
        for (int i = 1; i < 35; i++) words[i] = 8'(i);
        run_load(0, -1, 0, -1, 1'b0, fa0);
        run_load(0, 3, 5, -1, 1'b0, fa1);
        chk("stall_apply_delay", fa1 - fa0, 5);

        // Short stream with a partial final word.
        words[0] = 8'hFF; words[1] = 8'hFF; words[2] = 8'h3C;
        run_load(1, -1, 0, -1, 1'b0, fa_tmp);

        // Abort mid-stream, then a clean full load.
        for (int i = 0; i < 35; i++) words[i] = 8'($urandom);
        run_load(0, -1, 0, 100, 1'b0, fa_tmp);
        run_load(0, -1, 0, -1, 1'b0, fa_tmp);

        // Randomised words, VALID gaps and stray START pulses while busy.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 35; i++) words[i] = 8'($urandom);
            if (r == 2) run_load(r % 2, -1, 0, int'($urandom_range(0, 250)), 1'b1, fa_tmp);
            else if (r == 3) run_load(1, -1, 0, int'($urandom_range(0, 18)), 1'b1, fa_tmp);
            else run_load(r % 2, -1, 0, -1, 1'b1, fa_tmp);
        end

        // Reset in the middle of a load behaves like ABORT.
        st[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        for (int c = 0; c < 40; c++) begin
            vl[0] = 1'b1; data = 8'($urandom);
            tick();
        end
        RES = 1'b1; st[0] = 1'b1;
        tick();
        check_idle(0, "midload_reset");
        RES = 1'b0; st[0] = 1'b0; vl[0] = 1'b0;
        tick();
        check_idle(0, "post_reset_idle");
        for (int i = 0; i < 35; i++) words[i] = 8'($urandom);
        run_load(0, -1, 0, -1, 1'b0, fa_tmp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
